area_interp_engine: RTL

- Parametrised, pipelined successor to the single-channel scaling datapath.
- Takes the four source neighbours of one target pixel and their four area weights, and produces one scaled output pixel per accepted input.
- Supports multi-channel pixels, selectable interpolation mode, valid/ready backpressure, and output raster-coordinate tracking with an end-of-frame marker.
- Sits between the area generator / edge-tuning stage and the output image writer.

---
 rtl/area_interp_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/area_interp_engine.sv
// Three-stage area/nearest/pass interpolation engine with valid/ready flow control
// and raster coordinate tracking of the emitted pixels.
module area_interp_engine #(
  parameter int PIX_W      = 16,
  parameter int CH         = 1,
  parameter int WGT_W      = 16,
  parameter int NORM_SHIFT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*PIX_W-1:0]   imgmn,
  input  logic [CH*PIX_W-1:0]   imgm1n,
  input  logic [CH*PIX_W-1:0]   imgmn1,
  input  logic [CH*PIX_W-1:0]   imgm1n1,
  input  logic [WGT_W-1:0]      Amn,
  input  logic [WGT_W-1:0]      Am1n,
  input  logic [WGT_W-1:0]      Amn1,
  input  logic [WGT_W-1:0]      Am1n1,
  input  logic [1:0]            mode,
  input  logic [15:0]           frame_w,
  input  logic [15:0]           frame_h,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*PIX_W-1:0]   out_img,
  output logic [15:0]           out_x,
  output logic [15:0]           out_y,
  output logic                  out_last,
  output logic                  sat_flag
);

  localparam int BUS_W  = CH * PIX_W;
  localparam int PROD_W = PIX_W + WGT_W;
  localparam int SUM_W  = PROD_W + 3;
  localparam logic [SUM_W-1:0] ONE     = 1;
  localparam logic [SUM_W-1:0] RND     = (ONE << NORM_SHIFT) >> 1;
  localparam logic [SUM_W-1:0] PIX_MAX = (ONE << PIX_W) - ONE;
  localparam logic [1:0] MODE_NEAR = 2'b01;
  localparam logic [1:0] MODE_PASS = 2'b10;

  logic advance;
  logic out_hs;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !reset;
  assign out_hs   = out_valid && out_ready;

  logic             s1_valid;
  logic [BUS_W-1:0] s1_pix [4];
  logic [WGT_W-1:0] s1_wgt [4];
  logic [1:0]       s1_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_pix[0] <= imgmn;
      s1_pix[1] <= imgm1n;
      s1_pix[2] <= imgmn1;
      s1_pix[3] <= imgm1n1;
      s1_wgt[0] <= Amn;
      s1_wgt[1] <= Am1n;
      s1_wgt[2] <= Amn1;
      s1_wgt[3] <= Am1n1;
      s1_mode   <= mode;
    end
  end

  // Strict greater-than keeps the earlier neighbour on ties (mn > m1n > mn1 > m1n1).
  logic [1:0]       near_idx;
  logic [WGT_W-1:0] near_w;

  always_comb begin
    near_idx = 2'd0;
    near_w   = s1_wgt[0];
    for (int i = 1; i < 4; i++) begin
      if (s1_wgt[i] > near_w) begin
        near_w   = s1_wgt[i];
        near_idx = 2'(i);
      end
    end
  end

  logic              s2_valid;
  logic [PROD_W-1:0] s2_prod [4][CH];
  logic [BUS_W-1:0]  s2_sel;
  logic [1:0]        s2_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_sel   <= (s1_mode == MODE_NEAR) ? s1_pix[near_idx] : s1_pix[0];
      for (int n = 0; n < 4; n++) begin
        for (int c = 0; c < CH; c++) begin
          s2_prod[n][c] <= PROD_W'(s1_pix[n][c*PIX_W +: PIX_W]) * PROD_W'(s1_wgt[n]);
        end
      end
    end
  end

  logic [SUM_W-1:0] shifted [CH];
  logic [CH-1:0]    chan_sat;
  logic [BUS_W-1:0] area_img;

  always_comb begin
    chan_sat = '0;
    area_img = '0;
    for (int c = 0; c < CH; c++) begin
      shifted[c] = (SUM_W'(s2_prod[0][c]) + SUM_W'(s2_prod[1][c]) +
                    SUM_W'(s2_prod[2][c]) + SUM_W'(s2_prod[3][c]) + RND) >> NORM_SHIFT;
      chan_sat[c] = shifted[c] > PIX_MAX;
      area_img[c*PIX_W +: PIX_W] = chan_sat[c] ? {PIX_W{1'b1}} : shifted[c][PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_img   <= '0;
      sat_flag  <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_mode == MODE_NEAR || s2_mode == MODE_PASS) begin
        out_img  <= s2_sel;
        sat_flag <= 1'b0;
      end else begin
        out_img  <= area_img;
        sat_flag <= |chan_sat;
      end
    end
  end

  logic [15:0] fw, fh, eff_w, eff_h;
  logic        last_x, last_y;

  assign eff_w    = (fw == 16'd0) ? 16'd1 : fw;
  assign eff_h    = (fh == 16'd0) ? 16'd1 : fh;
  assign last_x   = out_x == eff_w - 16'd1;
  assign last_y   = out_y == eff_h - 16'd1;
  assign out_last = out_valid && last_x && last_y;

  // Frame size is only sampled while idle at the frame origin, so a frame keeps its geometry.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_x <= 16'd0;
      out_y <= 16'd0;
      fw    <= 16'd0;
      fh    <= 16'd0;
    end else begin
      if (out_x == 16'd0 && out_y == 16'd0 && !out_hs) begin
        fw <= frame_w;
        fh <= frame_h;
      end
      if (out_hs) begin
        if (last_x && last_y) begin
          out_x <= 16'd0;
          out_y <= 16'd0;
        end else if (last_x) begin
          out_x <= 16'd0;
          out_y <= out_y + 16'd1;
        end else begin
          out_x <= out_x + 16'd1;
        end
      end
    end
  end

endmodule
